rf16b_clk_en: RTL and testbench

//   16-bit (parameterisable) data register with clock enable and synchronous reset.

---
 rtl/rf16b_clk_en.sv | 39 +++
 tb/tb_rf16b_clk_en.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rf16b_clk_en.sv
// Purpose: WIDTH-bit data register with capture enable and synchronous reset, clocked on the falling edge of clk_n.
// Latency: D sampled at a falling edge of clk_n is on Q right after that edge; Q is driven only by a flop, never combinationally.
// Backpressure: none; clk_en low holds Q. Optional feature macro RF16B_VALID_FLAG_EN adds the sticky q_valid output.
module rf16b_clk_en #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef RF16B_VALID_FLAG_EN
  ,
  output logic             q_valid
`endif
);

  // Data word: reset has priority over enable. With the enable low, Q holds, so X/Z on D cannot reach it.
  always_ff @(negedge clk_n) begin
    if (rst) begin
      Q <= RESET_VALUE;
    end else if (clk_en) begin
      Q <= D;
    end
  end

`ifdef RF16B_VALID_FLAG_EN
  // Sticky flag: set by the first enabled capture after reset, and cleared only by reset.
  always_ff @(negedge clk_n) begin
    if (rst) begin
      q_valid <= 1'b0;
    end else if (clk_en) begin
      q_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf16b_clk_en.sv
// Bench for rf16b_clk_en. clk_n has a 50 ns period and starts high.
// Stimulus changes 3 ns after each rising edge, and the DUT updates on falling edges.
// The directed phase pins literal values. The random phase is checked against a capture-history model.
module tb_rf16b_clk_en;
  localparam int W = 16;

  logic         clk_n = 1'b1;
  logic         rst;
  logic         clk_en;
  logic [W-1:0] d;
  logic [W-1:0] q;
`ifdef RF16B_VALID_FLAG_EN
  logic         q_valid;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the words accepted since the last reset. Q is the newest of them, or the reset value if there are none.
  logic [W-1:0] hist[$];
  bit           m_known = 1'b0;

  initial forever #25 clk_n = ~clk_n;

  rf16b_clk_en #(
    .WIDTH      (W),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .clk_en(clk_en),
    .D     (d),
    .Q     (q)
`ifdef RF16B_VALID_FLAG_EN
    ,
    .q_valid(q_valid)
`endif
  );

  function automatic logic [W-1:0] model_q();
    if (hist.size() == 0) return 16'h0000;
    return hist[hist.size()-1];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update at each active edge, using the same sampled inputs the DUT sees.
  always @(negedge clk_n) begin
    if (rst === 1'b1) begin
      hist.delete();
      m_known <= 1'b1;
    end else if (clk_en === 1'b1) begin
      hist.push_back(d);
      m_known <= 1'b1;
    end
  end

  // Per-cycle comparison at the rising edge, half a period away from the active edge.
  always @(posedge clk_n) begin
    if (m_known) begin
      chk("model_q", q, model_q());
`ifdef RF16B_VALID_FLAG_EN
      chk("model_q_valid", {{(W-1){1'b0}}, q_valid}, {{(W-1){1'b0}}, hist.size() != 0});
`endif
    end
  end

  task automatic chk_v(input string nm, input logic exp);
`ifdef RF16B_VALID_FLAG_EN
    chk(nm, {{(W-1){1'b0}}, q_valid}, {{(W-1){1'b0}}, exp});
`endif
  endtask

  // Call at rising edge + 3 ns. The task drives one cycle, checks that Q has not yet moved, then checks Q just after the falling edge.
  task automatic cyc(input logic r, input logic e, input logic [W-1:0] dv,
                     input logic [W-1:0] exp_before, input logic [W-1:0] exp_after,
                     input string nm);
    rst = r; clk_en = e; d = dv;
    #10;
    chk({nm, "_before_edge"}, q, exp_before);
    @(negedge clk_n); #1;
    chk(nm, q, exp_after);
    @(posedge clk_n); #3;
  endtask

  initial begin
    logic [W-1:0] seq [5];
    logic [W-1:0] prev;
    seq = '{16'h2222, 16'h4444, 16'h8888, 16'hcccc, 16'hffff};

    // Reset for two falling edges, with the enable low and D unknown.
    rst = 1'b1; clk_en = 1'b0; d = 'x;
    @(negedge clk_n); #1;
    chk("reset_edge1", q, 16'h0000);
    chk_v("valid_after_reset", 1'b0);
    @(posedge clk_n); #3;
    cyc(1'b1, 1'b0, 'x, 16'h0000, 16'h0000, "reset_edge2");

    // With the enable low, Q must ignore D.
    cyc(1'b0, 1'b0, 16'hdddd, 16'h0000, 16'h0000, "gate1");
    cyc(1'b0, 1'b0, 16'hdddd, 16'h0000, 16'h0000, "gate2");
    chk_v("valid_gated", 1'b0);

    // First enabled capture.
    cyc(1'b0, 1'b1, 16'h1111, 16'h0000, 16'h1111, "cap1111");
    chk_v("valid_first_cap", 1'b1);

    // Q follows a run of enabled captures.
    prev = 16'h1111;
    foreach (seq[i]) begin
      cyc(1'b0, 1'b1, seq[i], prev, seq[i], $sformatf("follow%0d", i));
      prev = seq[i];
    end

    // When the enable drops, both Q and the valid flag hold.
    cyc(1'b0, 1'b0, 16'h1234, 16'hffff, 16'hffff, "en_drop");
    chk_v("valid_sticky", 1'b1);

    // Reset wins over the enable, and the data on that edge is discarded.
    cyc(1'b1, 1'b1, 16'haaaa, 16'hffff, 16'h0000, "rst_beats_en");
    chk_v("valid_cleared", 1'b0);
    cyc(1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000, "gate_after_rst");
    chk_v("valid_stays_clear", 1'b0);

    // Random traffic with occasional mid-stream resets, checked by the compare process.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 15) == 0);
      clk_en = $urandom_range(0, 1) == 1;
      d      = W'($urandom);
      @(posedge clk_n); #3;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
